// File: rtl/multicycle_control_unit.sv
// Control unit for a multi-cycle RISC-V style CPU.
// Sequences each instruction through IF/ID/EX/MEM/WB. It stalls IF and MEM
// until the unified memory reports ready, parks in HALT on a halting ECALL,
// and counts retired instructions.
//
// Ports:
//   clk, reset (async, active-low)
//   opcode, bcond, ecall_halt, mem_ready          - status from the datapath and memory
//   pc_write, pc_source, ir_write, i_or_d,
//   mem_read, mem_write, reg_write, mem_to_reg,
//   alu_src_a, alu_src_b, alu_op                  - datapath enables and selects
//   is_halted, retired                            - status out
module multicycle_control_unit #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 bcond,
    input  logic                 ecall_halt,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic [1:0]           pc_source,
    output logic                 ir_write,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic [1:0]           mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 is_halted,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t state, state_nxt;
    logic   retire;

    // Ungated control values decoded from the current state
    logic       pw_c, irw_c, iod_c, mr_c, mw_c, rw_c, a_c, halt_c;
    logic [1:0] ps_c, mtr_c, b_c, op_c;

    // State register and retire counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IF;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (retire) retired <= retired + CNT_WIDTH'(1);
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        pw_c      = 1'b0;
        ps_c      = 2'd0;
        irw_c     = 1'b0;
        iod_c     = 1'b0;
        mr_c      = 1'b0;
        mw_c      = 1'b0;
        rw_c      = 1'b0;
        mtr_c     = 2'd0;
        a_c       = 1'b0;
        b_c       = 2'd0;
        op_c      = 2'd0;
        halt_c    = 1'b0;

        case (state)
            S_IF: begin
                mr_c  = 1'b1;
                irw_c = mem_ready;
                if (mem_ready) state_nxt = S_ID;
            end
            S_ID: begin
                if (opcode == OP_ECALL) begin
                    if (ecall_halt) begin
                        state_nxt = S_HALT;
                    end else begin
                        pw_c      = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_IF;
                    end
                end else begin
                    state_nxt = S_EX;
                end
            end
            S_EX: begin
                case (opcode)
                    OP_R: begin
                        a_c = 1'b1; b_c = 2'd0; op_c = 2'd2; state_nxt = S_WB;
                    end
                    OP_I: begin
                        a_c = 1'b1; b_c = 2'd2; op_c = 2'd2; state_nxt = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        a_c = 1'b1; b_c = 2'd2; op_c = 2'd0; state_nxt = S_MEM;
                    end
                    OP_JAL: begin
                        a_c = 1'b0; b_c = 2'd2; op_c = 2'd0; state_nxt = S_WB;
                    end
                    OP_JALR: begin
                        a_c = 1'b1; b_c = 2'd2; op_c = 2'd0; state_nxt = S_WB;
                    end
                    OP_BRANCH: begin
                        a_c       = 1'b1;
                        b_c       = 2'd0;
                        op_c      = 2'd1;
                        pw_c      = 1'b1;
                        ps_c      = bcond ? 2'd2 : 2'd0;
                        retire    = 1'b1;
                        state_nxt = S_IF;
                    end
                    default: begin
                        // Unrecognised opcode retires as a NOP
                        pw_c      = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_IF;
                    end
                endcase
            end
            S_MEM: begin
                iod_c = 1'b1;
                if (opcode == OP_LOAD) begin
                    mr_c = 1'b1;
                    if (mem_ready) state_nxt = S_WB;
                end else if (opcode == OP_STORE) begin
                    mw_c = 1'b1;
                    if (mem_ready) begin
                        pw_c      = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_IF;
                    end
                end else begin
                    state_nxt = S_IF;
                end
            end
            S_WB: begin
                rw_c      = 1'b1;
                pw_c      = 1'b1;
                retire    = 1'b1;
                state_nxt = S_IF;
                if (opcode == OP_JAL || opcode == OP_JALR) begin
                    mtr_c = 2'd2;
                    ps_c  = 2'd1;
                end else if (opcode == OP_LOAD) begin
                    mtr_c = 2'd1;
                end
            end
            S_HALT: begin
                halt_c = 1'b1;
            end
            default: begin
                state_nxt = S_IF;
            end
        endcase
    end

    // Hold every control at zero while reset is asserted so that no write
    // can complete at the first edge after an asynchronous reset.
    assign pc_write   = reset & pw_c;
    assign pc_source  = reset ? ps_c  : 2'd0;
    assign ir_write   = reset & irw_c;
    assign i_or_d     = reset & iod_c;
    assign mem_read   = reset & mr_c;
    assign mem_write  = reset & mw_c;
    assign reg_write  = reset & rw_c;
    assign mem_to_reg = reset ? mtr_c : 2'd0;
    assign alu_src_a  = reset & a_c;
    assign alu_src_b  = reset ? b_c   : 2'd0;
    assign alu_op     = reset ? op_c  : 2'd0;
    assign is_halted  = reset & halt_c;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_multicycle_control_unit;

    localparam int unsigned CNT_WIDTH = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [6:0]           opcode;
    logic                 bcond;
    logic                 ecall_halt;
    logic                 mem_ready;
    logic                 pc_write;
    logic [1:0]           pc_source;
    logic                 ir_write;
    logic                 i_or_d;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic [1:0]           mem_to_reg;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           alu_op;
    logic                 is_halted;
    logic [CNT_WIDTH-1:0] retired;

    int n_cmp = 0;
    int n_err = 0;
    logic [CNT_WIDTH-1:0] exp_ret;

    multicycle_control_unit #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .bcond      (bcond),
        .ecall_halt (ecall_halt),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .is_halted  (is_halted),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // All control outputs packed for one-shot comparison
    logic [15:0] ctl;
    assign ctl = {pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write,
                  reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, is_halted};

    function automatic logic [15:0] ctl_of(input logic pw, input logic [1:0] ps,
                                           input logic irw, input logic iod,
                                           input logic mr, input logic mw,
                                           input logic rw, input logic [1:0] mtr,
                                           input logic a, input logic [1:0] b,
                                           input logic [1:0] op, input logic h);
        return {pw, ps, irw, iod, mr, mw, rw, mtr, a, b, op, h};
    endfunction

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [6:0] OP_UNK    = 7'b1111111;

    //                                 pw    ps    irw   iod   mr    mw    rw    mtr   a     b     op    h
    localparam logic [15:0] C_ZERO   = 16'h0000;
    localparam logic [15:0] C_IF     = ctl_of(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    localparam logic [15:0] C_IFW    = ctl_of(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    localparam logic [15:0] C_ID     = 16'h0000;
    localparam logic [15:0] C_EX_R   = ctl_of(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd2, 1'b0);
    localparam logic [15:0] C_EX_I   = ctl_of(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd2, 1'b0);
    localparam logic [15:0] C_EX_M   = ctl_of(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd0, 1'b0);
    localparam logic [15:0] C_EX_JAL = ctl_of(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 2'd0, 1'b0);
    localparam logic [15:0] C_EX_BT  = ctl_of(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0);
    localparam logic [15:0] C_EX_BN  = ctl_of(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0);
    localparam logic [15:0] C_PC4    = ctl_of(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    localparam logic [15:0] C_MEM_LW = ctl_of(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    localparam logic [15:0] C_MEM_SW = ctl_of(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    localparam logic [15:0] C_MEM_SD = ctl_of(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    localparam logic [15:0] C_WB_ALU = ctl_of(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    localparam logic [15:0] C_WB_LD  = ctl_of(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0);
    localparam logic [15:0] C_WB_J   = ctl_of(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0);
    localparam logic [15:0] C_HALT   = ctl_of(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1);

    task automatic test_reset();
        reset = 1'b0; opcode = OP_R; bcond = 1'b0; ecall_halt = 1'b0; mem_ready = 1'b1;
        exp_ret = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (ctl !== C_ZERO) begin
                n_err++; $display("FAIL reset cyc%0d ctl got %h want %h", i, ctl, C_ZERO);
            end
            n_cmp++;
            if (retired !== '0) begin
                n_err++; $display("FAIL reset cyc%0d retired got %0d want 0", i, retired);
            end
        end
    endtask

    // Shared per-task sequencing: ev = expected controls, rdy = mem_ready, rt = retire this cycle
    task automatic test_r();
        logic [15:0] ev [4] = '{C_IF, C_ID, C_EX_R, C_WB_ALU};
        logic        rt [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); reset = 1'b1; opcode = OP_R; mem_ready = 1'b1; #1;
            n_cmp++;
            if (ctl !== ev[i]) begin
                n_err++; $display("FAIL r_type cyc%0d ctl got %h want %h", i, ctl, ev[i]);
            end
            n_cmp++;
            if (retired !== exp_ret) begin
                n_err++; $display("FAIL r_type cyc%0d retired got %0d want %0d", i, retired, exp_ret);
            end
            if (rt[i]) exp_ret++;
        end
    endtask

    task automatic test_load_wait();
        logic [15:0] ev  [7] = '{C_IF, C_ID, C_EX_M, C_MEM_LW, C_MEM_LW, C_MEM_LW, C_WB_LD};
        logic        rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        rt  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); opcode = OP_LOAD; mem_ready = rdy[i]; #1;
            n_cmp++;
            if (ctl !== ev[i]) begin
                n_err++; $display("FAIL load cyc%0d ctl got %h want %h", i, ctl, ev[i]);
            end
            n_cmp++;
            if (retired !== exp_ret) begin
                n_err++; $display("FAIL load cyc%0d retired got %0d want %0d", i, retired, exp_ret);
            end
            if (rt[i]) exp_ret++;
        end
    endtask

    task automatic test_branch();
        logic [15:0] ev [6] = '{C_IF, C_ID, C_EX_BT, C_IF, C_ID, C_EX_BN};
        logic        bc [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        rt [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); opcode = OP_BRANCH; mem_ready = 1'b1; bcond = bc[i]; #1;
            n_cmp++;
            if (ctl !== ev[i]) begin
                n_err++; $display("FAIL branch cyc%0d ctl got %h want %h", i, ctl, ev[i]);
            end
            n_cmp++;
            if (retired !== exp_ret) begin
                n_err++; $display("FAIL branch cyc%0d retired got %0d want %0d", i, retired, exp_ret);
            end
            if (rt[i]) exp_ret++;
        end
        bcond = 1'b0;
    endtask

    // JALR, JAL, I-ALU and an unknown opcode, back to back
    task automatic test_back_to_back();
        logic [6:0]  op [15] = '{OP_JALR, OP_JALR, OP_JALR, OP_JALR,
                                 OP_JAL, OP_JAL, OP_JAL, OP_JAL,
                                 OP_I, OP_I, OP_I, OP_I,
                                 OP_UNK, OP_UNK, OP_UNK};
        logic [15:0] ev [15] = '{C_IF, C_ID, C_EX_M, C_WB_J,
                                 C_IF, C_ID, C_EX_JAL, C_WB_J,
                                 C_IF, C_ID, C_EX_I, C_WB_ALU,
                                 C_IF, C_ID, C_PC4};
        logic        rt [15] = '{1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); opcode = op[i]; mem_ready = 1'b1; #1;
            n_cmp++;
            if (ctl !== ev[i]) begin
                n_err++; $display("FAIL b2b cyc%0d op %b ctl got %h want %h", i, op[i], ctl, ev[i]);
            end
            n_cmp++;
            if (retired !== exp_ret) begin
                n_err++; $display("FAIL b2b cyc%0d retired got %0d want %0d", i, retired, exp_ret);
            end
            if (rt[i]) exp_ret++;
        end
    endtask

    task automatic test_ecall_halt();
        logic [15:0] ev [4] = '{C_IF, C_PC4, C_IF, C_ID};
        logic        eh [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic        rt [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); opcode = OP_ECALL; mem_ready = 1'b1; ecall_halt = eh[i]; #1;
            n_cmp++;
            if (ctl !== ev[i]) begin
                n_err++; $display("FAIL ecall cyc%0d ctl got %h want %h", i, ctl, ev[i]);
            end
            n_cmp++;
            if (retired !== exp_ret) begin
                n_err++; $display("FAIL ecall cyc%0d retired got %0d want %0d", i, retired, exp_ret);
            end
            if (rt[i]) exp_ret++;
        end
        // HALT must ignore every input
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            opcode = 7'(i * 13); mem_ready = i[0]; bcond = i[1]; ecall_halt = i[2]; #1;
            n_cmp++;
            if (ctl !== C_HALT) begin
                n_err++; $display("FAIL halt cyc%0d ctl got %h want %h", i, ctl, C_HALT);
            end
            n_cmp++;
            if (retired !== exp_ret) begin
                n_err++; $display("FAIL halt cyc%0d retired got %0d want %0d", i, retired, exp_ret);
            end
        end
        @(negedge clk); reset = 1'b0; ecall_halt = 1'b0; bcond = 1'b0; #1;
        exp_ret = '0;
        n_cmp++;
        if (is_halted !== 1'b0) begin
            n_err++; $display("FAIL halt_reset is_halted got %b want 0", is_halted);
        end
        n_cmp++;
        if (retired !== exp_ret) begin
            n_err++; $display("FAIL halt_reset retired got %0d want 0", retired);
        end
    endtask

    task automatic test_store_reset();
        logic [15:0] ev  [9] = '{C_IFW, C_IF, C_ID, C_EX_M, C_MEM_SD,
                                 C_IF, C_ID, C_EX_M, C_MEM_SW};
        logic        rdy [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b0};
        logic        rt  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); reset = 1'b1; opcode = OP_STORE; mem_ready = rdy[i]; #1;
            n_cmp++;
            if (ctl !== ev[i]) begin
                n_err++; $display("FAIL store cyc%0d ctl got %h want %h", i, ctl, ev[i]);
            end
            n_cmp++;
            if (retired !== exp_ret) begin
                n_err++; $display("FAIL store cyc%0d retired got %0d want %0d", i, retired, exp_ret);
            end
            if (rt[i]) exp_ret++;
        end
        // Reset in the middle of the stalled store
        #1 reset = 1'b0; #1;
        exp_ret = '0;
        n_cmp++;
        if (ctl !== C_ZERO) begin
            n_err++; $display("FAIL store_reset ctl got %h want %h", ctl, C_ZERO);
        end
        n_cmp++;
        if (retired !== exp_ret) begin
            n_err++; $display("FAIL store_reset retired got %0d want 0", retired);
        end
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); reset = 1'b1; #1;
        n_cmp++;
        if (ctl !== C_IF) begin
            n_err++; $display("FAIL store_release ctl got %h want %h", ctl, C_IF);
        end
        n_cmp++;
        if (retired !== exp_ret) begin
            n_err++; $display("FAIL store_release retired got %0d want 0", retired);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (ctl !== C_ID) begin
            n_err++; $display("FAIL store_after ctl got %h want %h", ctl, C_ID);
        end
    endtask

    initial begin
        test_reset();
        test_r();
        test_load_wait();
        test_branch();
        test_back_to_back();
        test_ecall_halt();
        test_store_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
